mem_arbiter: RTL

Two-port arbiter and access sequencer sitting in front of `memory_controller`, sharing its single address/data/we port between requester 0 (CPU) and requester 1 (debug/DMA port). It grants one requester at a time with round-robin fairness and an optional lock for back-to-back accesses. It drives the controller for exactly one access cycle, registers the read data and returns a one-cycle acknowledge. Addresses outside the populated map are rejected with an error flag, and no write is issued for them.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/rr_pick2.sv | 20 ++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// the populated address map and the address-fault test.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // Populated map: ROM 0000-001F, I/O 0020-003F, RAM 0040-005F.
   localparam logic [15:0] ROM_BASE = 16'h0000;
   localparam logic [15:0] IO_BASE  = 16'h0020;
   localparam logic [15:0] RAM_BASE = 16'h0040;
   localparam logic [15:0] MAP_END  = 16'h005F;

   // Anything above MAP_END faults: either a bit above bit 6 is set, or the
   // address falls in the unpopulated 0060-007F window.
   function automatic logic addr_fault(input logic [15:0] addr);
      return (addr[15:7] != 9'd0) || (addr[6:5] == 2'b11);
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles both requester handshakes and the memory-controller port.
//   slave  : the arbiter (takes requests and mem_rdata, returns acks and
//            drives the mem_* command signals)
//   master : the environment (requesters plus the memory controller)
// Per requester: req, lock, we, addr, wdata in; ack, err, rdata out.
// Memory side: mem_addr, mem_wdata, mem_we out; mem_rdata in. busy out.
interface mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic              req0, req1;
   logic              lock0, lock1;
   logic              we0, we1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              ack0, ack1;
   logic              err0, err1;
   logic [DATA_W-1:0] rdata0, rdata1;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;

   modport slave (
      input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
      input  mem_rdata,
      output ack0, ack1, err0, err1, rdata0, rdata1,
      output mem_addr, mem_wdata, mem_we, busy
   );

   modport master (
      output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
      output mem_rdata,
      input  ack0, ack1, err0, err1, rdata0, rdata1,
      input  mem_addr, mem_wdata, mem_we, busy
   );
endinterface

// File: rtl/rr_pick2.sv
// rr_pick2
// Combinational two-way round-robin pick.
//   req0, req1 : requests
//   last       : requester served most recently
//   grant      : at least one request is pending
//   winner     : selected requester (valid when grant is high)
module rr_pick2 (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic grant,
   output logic winner
);

   assign grant  = req0 | req1;
   // On a tie the requester that was not served last wins; otherwise the
   // only active requester wins.
   assign winner = (req0 && req1) ? ~last : req1;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single memory_controller port between two requesters with
// round-robin fairness and an optional lock for back-to-back accesses.
// Each access drives the controller for one ACCESS cycle, registers the read
// data and returns a one-cycle ack (with err for out-of-map addresses).
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : requester handshakes and memory port (mem_arbiter_if.slave)
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input  logic          clock,
   input  logic          reset_n,
   mem_arbiter_if.slave  bus
);

   state_t            state, state_nxt;
   logic              grant, winner;
   logic              owner, last;
   logic              load, load_sel, relock;
   logic [ADDR_W-1:0] addr_q, sel_addr;
   logic [DATA_W-1:0] wdata_q, sel_wdata;
   logic              we_q, sel_we, fault;
   logic              ack0_q, ack1_q, err0_q, err1_q;
   logic [DATA_W-1:0] rdata0_q, rdata1_q;

   rr_pick2 u_pick (
      .req0   (bus.req0),
      .req1   (bus.req1),
      .last   (last),
      .grant  (grant),
      .winner (winner)
   );

   // Fault is judged on the latched address so it is stable for the whole
   // ACCESS cycle and independent of the live request inputs.
   assign fault  = addr_fault(addr_q);
   assign relock = owner ? (bus.lock1 && bus.req1) : (bus.lock0 && bus.req0);

   assign sel_addr  = load_sel ? bus.addr1  : bus.addr0;
   assign sel_wdata = load_sel ? bus.wdata1 : bus.wdata0;
   assign sel_we    = load_sel ? bus.we1    : bus.we0;

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      load_sel  = owner;
      case (state)
         ST_IDLE: begin
            if (grant) begin
               state_nxt = ST_ACCESS;
               load      = 1'b1;
               load_sel  = winner;
            end
         end
         ST_ACCESS: state_nxt = ST_DONE;
         ST_DONE: begin
            // The owner's next access is already on its port: keep the grant.
            if (relock) begin
               state_nxt = ST_ACCESS;
               load      = 1'b1;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         owner    <= 1'b0;
         last     <= 1'b1;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         err0_q   <= 1'b0;
         err1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         if (load) begin
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            we_q    <= sel_we;
            owner   <= load_sel;
         end
         // The read is sampled at the edge that ends ACCESS.
         if (state == ST_ACCESS) begin
            last <= owner;
            if (owner) begin
               ack1_q   <= 1'b1;
               err1_q   <= fault;
               rdata1_q <= fault ? '0 : bus.mem_rdata;
            end else begin
               ack0_q   <= 1'b1;
               err0_q   <= fault;
               rdata0_q <= fault ? '0 : bus.mem_rdata;
            end
         end
      end
   end

   // mem_we decodes only registered state, so reset drops it immediately.
   assign bus.mem_we    = (state == ST_ACCESS) && we_q && !fault;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.busy      = (state != ST_IDLE);
   assign bus.ack0      = ack0_q;
   assign bus.ack1      = ack1_q;
   assign bus.err0      = err0_q;
   assign bus.err1      = err1_q;
   assign bus.rdata0    = rdata0_q;
   assign bus.rdata1    = rdata1_q;

endmodule
